// File: rtl/serial_mem_slave.sv
// serial_mem_slave: one-wire request/grant serial slave backed by a word memory.
// Frame: request (rx low) -> grant (tx low, or SPLIT while busy) -> ready gap ->
// address -> burst length -> mode bit -> LEN+1 data beats -> done.
// All serial fields are LSB first, one bit per clock.
// Optional build macro SERIAL_MEM_SLAVE_PARITY_EN appends an even-parity bit
// to every data beat (sampled on writes, driven on reads).
//
// Handshake: the master requests by holding rx low for a sampled cycle in IDLE;
// the slave grants by driving tx low. While busy is high the grant is withheld
// (SPLIT). A SPLIT lasting SPLIT_TIMEOUT cycles abandons the frame.
module serial_mem_slave #(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 8,
  parameter int MEM_DEPTH     = 4096,
  parameter int READY_GAP     = 4,
  parameter int BURST_W       = 2,
  parameter int SPLIT_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx,
  input  logic busy,
  output logic active,
  output logic abort,
  output logic parity_err
);

`ifdef SERIAL_MEM_SLAVE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Bits per beat on the wire, including the optional parity bit.
  localparam int BEAT_BITS = DATA_W + (PAR_EN ? 1 : 0);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared counter serves the gap, address, length, bit and split phases.
  localparam int CNT_MAX = max2(max2(ADDR_W, BEAT_BITS), max2(max2(READY_GAP, SPLIT_TIMEOUT), BURST_W));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(READY_GAP - 1);
  localparam logic [CNT_W-1:0] C_ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] C_LEN_LAST  = CNT_W'(BURST_W - 1);
  localparam logic [CNT_W-1:0] C_DATA_W    = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] C_BEAT_LAST = CNT_W'(BEAT_BITS - 1);
  localparam logic [CNT_W-1:0] C_BEAT_PEN  = CNT_W'(BEAT_BITS - 2);
  localparam logic [CNT_W-1:0] C_TO_LAST   = CNT_W'(SPLIT_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_SPLIT, S_READY, S_ADDR, S_LEN, S_MODE, S_WR, S_RD, S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [BURST_W-1:0]  r_len;
  logic [BURST_W-1:0]  r_beat;
  logic [DATA_W-1:0]   r_sh;
  logic [DATA_W-1:0]   r_word;
  logic                r_par;
  logic                r_tx;
  logic                r_active;
  logic                r_abort;
  logic                r_perr;

  logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

  logic                w_in_range;
  logic [DATA_W-1:0]   w_rd_word;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_par_ok;
  logic                w_last_bit;
  logic                w_we;

  // Address decode, read fetch and write-commit qualification.
  always_comb begin
    w_in_range = (32'(r_addr) < 32'(MEM_DEPTH));
    w_rd_word  = w_in_range ? r_mem[r_addr] : '0;
    // With parity the word is complete in r_sh; otherwise the last bit is still on rx.
    w_wdata    = PAR_EN ? r_sh : DATA_W'({rx, r_sh} >> 1);
    w_par_ok   = PAR_EN ? ((^r_sh) == rx) : 1'b1;
    w_last_bit = (r_cnt == C_BEAT_LAST);
    w_we       = !rst && (r_state == S_WR) && w_last_bit && w_par_ok && w_in_range;
  end

  // Memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_addr] <= w_wdata;
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_sh     <= '0;
      r_word   <= '0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
      r_active <= 1'b0;
      r_abort  <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      r_perr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!rx) begin
            r_state  <= S_REQ;
            r_active <= 1'b1;
          end
        end
        S_REQ: begin
          r_cnt <= '0;
          if (!busy) begin
            r_tx    <= 1'b0;
            r_state <= S_READY;
          end else begin
            r_state <= S_SPLIT;
          end
        end
        S_SPLIT: begin
          // Release wins over timeout when both happen on the same cycle.
          if (!busy) begin
            r_tx    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_READY;
          end else if (SPLIT_TIMEOUT != 0) begin
            if (r_cnt == C_TO_LAST) begin
              r_abort  <= 1'b1;
              r_active <= 1'b0;
              r_cnt    <= '0;
              r_state  <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_READY: begin
          if (r_cnt == C_GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= S_ADDR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ADDR: begin
          r_addr <= ADDR_W'({rx, r_addr} >> 1);
          if (r_cnt == C_ADDR_LAST) begin
            r_cnt   <= '0;
            r_state <= S_LEN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LEN: begin
          r_len <= BURST_W'({rx, r_len} >> 1);
          if (r_cnt == C_LEN_LAST) begin
            r_cnt   <= '0;
            r_state <= S_MODE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_MODE: begin
          r_cnt  <= '0;
          r_beat <= '0;
          if (rx) begin
            r_state <= S_WR;
          end else begin
            // First read word is fetched and its bit 0 launched on this edge.
            r_state <= S_RD;
            r_word  <= w_rd_word;
            r_par   <= ^w_rd_word;
            r_tx    <= w_rd_word[0];
            r_addr  <= r_addr + 1'b1;
          end
        end
        S_WR: begin
          if (r_cnt < C_DATA_W) begin
            r_sh <= DATA_W'({rx, r_sh} >> 1);
          end
          if (w_last_bit) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= '0;
            if (!w_par_ok) begin
              r_perr <= 1'b1;
            end
            if (r_beat == r_len) begin
              r_tx    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RD: begin
          if (r_cnt == C_BEAT_LAST) begin
            // Last bit of the beat has been on tx; start next beat or finish.
            r_cnt <= '0;
            if (r_beat == r_len) begin
              r_tx    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_beat <= r_beat + 1'b1;
              r_tx   <= r_word[0];
            end
          end else if (r_cnt == C_BEAT_PEN) begin
            // Launching the beat's last bit: prefetch the next word now.
            r_cnt  <= r_cnt + 1'b1;
            r_tx   <= PAR_EN ? r_par : r_word[1];
            r_word <= w_rd_word;
            r_par  <= ^w_rd_word;
            r_addr <= r_addr + 1'b1;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tx   <= r_word[1];
            r_word <= r_word >> 1;
          end
        end
        S_DONE: begin
          r_tx     <= 1'b1;
          r_active <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign active     = r_active;
  assign abort      = r_abort;
  assign parity_err = r_perr;

endmodule

// File: tb/tb_serial_mem_slave.sv
// Bench for serial_mem_slave: two instances (default, and a small-memory /
// short-timeout variant), directed and random frames checked against a
// word-array memory model and an expected-word queue.
module tb_serial_mem_slave;
  localparam int AW      = 12;
  localparam int DW      = 8;
  localparam int RG      = 4;
  localparam int BW      = 2;
  localparam int DEPTH_A = 4096;
  localparam int DEPTH_B = 3072;
`ifdef SERIAL_MEM_SLAVE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rx_a, busy_a, tx_a, active_a, abort_a, perr_a;
  logic rx_b, busy_b, tx_b, active_b, abort_b, perr_b;

  int total = 0;
  int bad   = 0;
  int sel   = 0;

  logic [DW-1:0] model_a [DEPTH_A];
  logic [DW-1:0] model_b [DEPTH_A];
  logic [DW-1:0] wq [$];
  logic [DW-1:0] exp_q [$];

  serial_mem_slave u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a), .busy(busy_a),
    .active(active_a), .abort(abort_a), .parity_err(perr_a)
  );

  serial_mem_slave #(.MEM_DEPTH(DEPTH_B), .SPLIT_TIMEOUT(8)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .tx(tx_b), .busy(busy_b),
    .active(active_b), .abort(abort_b), .parity_err(perr_b)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic g_tx();     return (sel != 0) ? tx_b     : tx_a;     endfunction
  function automatic logic g_active(); return (sel != 0) ? active_b : active_a; endfunction
  function automatic logic g_abort();  return (sel != 0) ? abort_b  : abort_a;  endfunction
  function automatic logic g_perr();   return (sel != 0) ? perr_b   : perr_a;   endfunction

  task automatic drive(input logic r, input logic b);
    if (sel != 0) begin rx_b = r; busy_b = b; end
    else begin rx_a = r; busy_a = b; end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (sel != 0) return (int'(a) < DEPTH_B) ? model_b[a] : '0;
    return model_a[a];
  endfunction

  task automatic model_wr(input logic [AW-1:0] a, input logic [DW-1:0] w);
    if (sel != 0) begin
      if (int'(a) < DEPTH_B) model_b[a] = w;
    end else begin
      model_a[a] = w;
    end
  endtask

  // One full frame as the bus master. Write data comes from wq.
  task automatic frame(input bit wr, input logic [AW-1:0] addr, input int len, input int split_n,
                       input int bad_par_beat, input int rst_beat, input int rst_bit);
    logic [AW-1:0] a;
    logic [BW-1:0] lv;
    logic [DW-1:0] w;
    logic [DW-1:0] cap;
    logic exp_pe;
    a = addr;
    lv = BW'(len);
    exp_pe = 1'b0;
    nx(); drive(1'b0, split_n > 0);
    nx(); chk("req_active", g_active(), 1); chk("req_tx", g_tx(), 1);
    drive(1'b1, (split_n > 0) ? 1'b1 : 1'b0);
    for (int k = 0; k < split_n; k++) begin
      nx(); chk("split_tx", g_tx(), 1); chk("split_abort", g_abort(), 0);
      drive(1'b1, (k == split_n - 1) ? 1'b0 : 1'b1);
    end
    nx(); chk("grant_tx", g_tx(), 0); drive(1'b1, 1'b0);
    for (int j = 1; j < RG; j++) begin nx(); chk("gap_tx", g_tx(), 0); drive(1'b1, 1'b0); end
    for (int i = 0; i < AW; i++) begin nx(); drive(addr[i], 1'b0); end
    for (int i = 0; i < BW; i++) begin nx(); drive(lv[i], 1'b0); end
    nx(); chk("mode_tx", g_tx(), 0); drive(wr, 1'b0);
    if (wr) begin
      for (int beat = 0; beat <= len; beat++) begin
        w = wq.pop_front();
        for (int b = 0; b < DW; b++) begin
          nx();
          chk("wr_perr", g_perr(), exp_pe);
          exp_pe = 1'b0;
          drive(w[b], 1'b0);
          if (beat == rst_beat && b == rst_bit) begin
            rst = 1'b1;
            nx();
            rst = 1'b0;
            chk("rst_tx", g_tx(), 1); chk("rst_active", g_active(), 0);
            drive(1'b1, 1'b0);
            return;
          end
        end
        if (PAR) begin
          nx(); drive((^w) ^ (beat == bad_par_beat), 1'b0);
          exp_pe = (beat == bad_par_beat);
        end
        if (!(PAR && beat == bad_par_beat)) model_wr(a, w);
        a = a + 1'b1;
      end
    end else begin
      for (int beat = 0; beat <= len; beat++) begin
        w = model_rd(a);
        for (int b = 0; b < DW; b++) begin
          nx(); chk("rd_bit", g_tx(), w[b]); cap[b] = g_tx(); drive(1'b1, 1'b0);
        end
        if (PAR) begin nx(); chk("rd_par", g_tx(), ^w); drive(1'b1, 1'b0); end
        if (exp_q.size() > 0) chk("rd_word", cap, exp_q.pop_front());
        a = a + 1'b1;
      end
    end
    nx(); chk("done_tx", g_tx(), 1); chk("done_active", g_active(), 1);
    chk("done_perr", g_perr(), exp_pe);
    drive(1'b1, 1'b0);
    nx(); chk("idle_active", g_active(), 0); chk("idle_tx", g_tx(), 1);
  endtask

  initial begin
    logic [AW-1:0] ra;
    int rl, sp;
    logic [DW-1:0] n0, n1;
    rst = 1'b1; rx_a = 1'b1; busy_a = 1'b0; rx_b = 1'b1; busy_b = 1'b0;
    repeat (3) @(negedge clk);
    // reset state
    sel = 0; chk("rst_a_tx", g_tx(), 1); chk("rst_a_active", g_active(), 0);
    chk("rst_a_abort", g_abort(), 0); chk("rst_a_perr", g_perr(), 0);
    sel = 1; chk("rst_b_tx", g_tx(), 1); chk("rst_b_active", g_active(), 0);
    rst = 1'b0;
    sel = 0;

    // single write then read back
    wq.push_back(8'hD3);
    frame(1'b1, 12'h005, 0, 0, -1, -1, -1);
    exp_q.push_back(8'hD3);
    frame(1'b0, 12'h005, 0, 0, -1, -1, -1);

    // burst write across the top of the address space
    wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33); wq.push_back(8'h44);
    frame(1'b1, 12'hFFF, 3, 0, -1, -1, -1);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    frame(1'b0, 12'hFFF, 3, 0, -1, -1, -1);
    exp_q.push_back(8'h22);
    frame(1'b0, 12'h000, 0, 0, -1, -1, -1);

    // SPLIT release after 10 busy cycles
    wq.push_back(8'hA5); wq.push_back(8'h3C);
    frame(1'b1, 12'h040, 1, 10, -1, -1, -1);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    frame(1'b0, 12'h040, 1, 10, -1, -1, -1);

    // reset during bit 4 of beat 2 of a burst write
    for (int k = 0; k < 4; k++) wq.push_back(DW'($urandom));
    frame(1'b1, 12'h100, 3, 0, -1, -1, -1);
    n0 = DW'($urandom); n1 = DW'($urandom);
    wq.delete();
    wq.push_back(n0); wq.push_back(n1); wq.push_back(~n0); wq.push_back(~n1);
    frame(1'b1, 12'h100, 3, 0, -1, 2, 4);
    wq.delete();
    exp_q.push_back(n0); exp_q.push_back(n1);
    frame(1'b0, 12'h100, 3, 0, -1, -1, -1);

    // SPLIT timeout on the short-timeout instance
    sel = 1;
    nx(); drive(1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      nx();
      chk("to_abort", g_abort(), (k == 10) ? 1 : 0);
      chk("to_active", g_active(), (k < 10) ? 1 : 0);
      chk("to_tx", g_tx(), 1);
      drive(1'b1, 1'b1);
    end
    drive(1'b1, 1'b0);

    // out-of-range words on the small-memory instance
    wq.push_back(8'h5E); wq.push_back(8'h6F); wq.push_back(8'h70); wq.push_back(8'h81);
    frame(1'b1, 12'd3070, 3, 0, -1, -1, -1);
    exp_q.push_back(8'h5E); exp_q.push_back(8'h6F); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    frame(1'b0, 12'd3070, 3, 0, -1, -1, -1);
    sel = 0;

`ifdef SERIAL_MEM_SLAVE_PARITY_EN
    // bad parity on a write leaves the stored word untouched
    wq.push_back(8'h5A);
    frame(1'b1, 12'h020, 0, 0, -1, -1, -1);
    wq.push_back(8'hD3);
    frame(1'b1, 12'h020, 0, 0, 0, -1, -1);
    exp_q.push_back(8'h5A);
    frame(1'b0, 12'h020, 0, 0, -1, -1, -1);
`endif

    // random frames: write then read back
    for (int r = 0; r < 6; r++) begin
      ra = AW'($urandom_range(0, DEPTH_A - 1));
      rl = $urandom_range(0, 3);
      sp = $urandom_range(0, 4);
      for (int k = 0; k <= rl; k++) wq.push_back(DW'($urandom));
      frame(1'b1, ra, rl, sp, -1, -1, -1);
      frame(1'b0, ra, rl, 0, -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
